// File: rtl/counter_irq_if.sv
// Bus and interrupt signals between the CPU and counter_irq_ctrl.
// The master side is the CPU and the slave side is the interrupt controller.
interface counter_irq_if;
  logic        bus_we;
  logic [1:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        irq;
  logic [1:0]  irq_cause;
  logic        irq_ack;

  modport master (
    output bus_we, bus_addr, bus_wdata, irq_ack,
    input  bus_rdata, irq, irq_cause
  );

  modport slave (
    input  bus_we, bus_addr, bus_wdata, irq_ack,
    output bus_rdata, irq, irq_cause
  );
endinterface

// File: rtl/counter_irq_ctrl.sv
// counter_irq_ctrl: turns the three 8253-style counter outputs into timer
// events. Each event sets a pending flag and bumps a saturating counter.
// Pending flags drive a maskable, prioritised interrupt. The CPU sees
// everything through a 4-word register window.
// Optional build macro COUNTER_IRQ_BOTHEDGE_EN: when it is defined, both
// edges of each input count as events (square-wave mode). Otherwise only
// rising edges do.
module counter_irq_ctrl #(
  parameter int CNT_W       = 8,  // 1..10
  parameter int SYNC_STAGES = 2   // 2 or 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       cnt_out,
  counter_irq_if.slave     bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [1:0]       NO_CAUSE = 2'b11;

  logic [2:0]         sync_q [SYNC_STAGES];
  logic [2:0]         hist_q;
  logic [SYNC_STAGES:0] arm_q;
  logic [2:0]         sync_lvl, evt, active, w1c, ack_clr;
  logic [2:0]         pending_q, pending_d, mask_q, mask_d;
  logic [CNT_W-1:0]   cnt_q [3];
  logic [CNT_W-1:0]   cnt_d [3];
  logic               irq_q;
  logic [1:0]         cause_q, cause_d;
  logic               wr_pend, wr_mask, wr_cnt;
  logic [3*CNT_W-1:0] cnt_packed;
  logic               unused_wdata;

  // Synchroniser chain, edge-history flop and post-reset arming shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      hist_q <= '0;
      arm_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the previous
      // stage's old value, so the chain shifts by one flop per clock.
      sync_q[0] <= cnt_out;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      hist_q <= sync_lvl;
      arm_q  <= {arm_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign sync_lvl = sync_q[SYNC_STAGES-1];

  // Edges are ignored until the chain and history hold real input levels.
  // Without this, an input that is already high at reset release would
  // show up as a false edge.
`ifdef COUNTER_IRQ_BOTHEDGE_EN
  assign evt = (sync_lvl ^ hist_q) & {3{arm_q[SYNC_STAGES]}};
`else
  assign evt = (sync_lvl & ~hist_q) & {3{arm_q[SYNC_STAGES]}};
`endif

  assign wr_pend = bus.bus_we && (bus.bus_addr == 2'd0);
  assign wr_mask = bus.bus_we && (bus.bus_addr == 2'd1);
  assign wr_cnt  = bus.bus_we && (bus.bus_addr == 2'd2);
  assign w1c     = wr_pend ? bus.bus_wdata[2:0] : 3'b000;
  assign active  = pending_q & mask_q;
  assign unused_wdata = ^bus.bus_wdata[31:3];

  // Next-state for the pending flags, mask and interrupt cause. A set beats a clear.
  always_comb begin
    // NOTE: assign every always_comb output a default first. A path that
    // leaves an output unassigned infers a latch.
    ack_clr = 3'b000;
    if (bus.irq_ack && irq_q && (cause_q != NO_CAUSE)) ack_clr[cause_q] = 1'b1;
    pending_d = (pending_q & ~(w1c | ack_clr)) | evt;
    mask_d    = wr_mask ? bus.bus_wdata[2:0] : mask_q;
    if (active[0])      cause_d = 2'd0;
    else if (active[1]) cause_d = 2'd1;
    else if (active[2]) cause_d = 2'd2;
    else                cause_d = NO_CAUSE;
  end

  // Saturating per-channel event counters. A clear write beats a same-cycle event.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = cnt_q[i];
      if (wr_cnt)                            cnt_d[i] = '0;
      else if (evt[i] && cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + 1'b1;
    end
  end

  // Control and status state: pending, mask, counters and the registered interrupt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      mask_q    <= '0;
      irq_q     <= 1'b0;
      cause_q   <= NO_CAUSE;
      // NOTE: the counter array is small and is read by software straight
      // after reset, so every entry gets an explicit reset.
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      pending_q <= pending_d;
      mask_q    <= mask_d;
      irq_q     <= |active;
      cause_q   <= cause_d;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign cnt_packed = {cnt_q[2], cnt_q[1], cnt_q[0]};

  // Read mux: combinational from the address. Unused bits read as zero.
  always_comb begin
    unique case (bus.bus_addr)
      2'd0:    bus.bus_rdata = {29'd0, pending_q};
      2'd1:    bus.bus_rdata = {29'd0, mask_q};
      2'd2:    bus.bus_rdata = 32'(cnt_packed);
      default: bus.bus_rdata = {irq_q, 24'd0, sync_lvl, 2'b00, cause_q};
    endcase
  end

  assign bus.irq       = irq_q;
  assign bus.irq_cause = cause_q;

endmodule

// File: doc/counter_irq_ctrl.md
Name: counter_irq_ctrl

Overview:
- Downstream consumer of the three-channel 8253-style counter outputs (counter0_OUT..counter2_OUT).
- Synchronises each output into the clk domain and detects rising edges as timer events.
- Latches each event as a pending flag and counts events per channel.
- Raises a maskable CPU interrupt with a priority cause; CPU accesses it through a 4-word IO register window.

Parameters:
CNT_W, 8, width of each per-channel saturating event counter (1..10).
SYNC_STAGES, 2, synchroniser depth per input (2 or 3).

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
cnt_out  input  3  counter channel outputs, bit i = channel i; asynchronous to clk
bus_we  input  1  register write strobe, one clk cycle per write
bus_addr  input  2  register select
bus_wdata  input  32  write data
bus_rdata  output  32  read data, combinational from bus_addr
irq  output  1  interrupt request, registered
irq_cause  output  2  highest-priority active channel; 2'b11 = none
irq_ack  input  1  one-cycle acknowledge; clears the pending bit of the current irq_cause

Behaviour:
- Reset:
  - All synchroniser and edge flops, pending[2:0], mask[2:0] and all event counters reset to 0.
  - Outputs after reset: irq=0, irq_cause=2'b11.
  - Reset takes effect immediately, including mid-event or mid-ack; no event is remembered across reset.
- Synchronisation and edge detection:
  - Per channel: SYNC_STAGES-flop synchroniser, then one history flop.
  - event_i = sync_i & ~hist_i, a single-clk pulse.
  - cnt_out must stay stable for at least SYNC_STAGES+1 clk periods; shorter pulses may be lost. This is acceptable.
- Latency (SYNC_STAGES=2), with cnt_out[i] rising before clk edge E1:
  - event_i is high between E2 and E3.
  - pending[i]=1 after E3.
  - irq=1 after E4, provided mask[i]=1.
- Pending flags:
  - Set on event_i.
  - Cleared by a write-1-to-clear (W1C) to address 0, or by irq_ack when irq_cause==i.
  - If a set and a clear hit the same cycle, the set wins (bit stays 1).
- Event counters:
  - Increment on each event_i, independent of mask.
  - Saturate at 2^CNT_W-1; no wrap-around.
  - Any write to address 2 clears all three counters. An event in the same cycle as that write is lost; the counter reads 0.
- Interrupt generation:
  - irq and irq_cause are registered from active = pending & mask.
  - irq = |active.
  - Priority: channel 0 > channel 1 > channel 2.
  - irq_ack while irq=0 has no effect.
  - After an ack, irq drops one clk later unless another active bit remains. In that case irq stays high and irq_cause moves to the next channel.
- Register map (unused bits read 0):
  - addr 0, pending, R/W1C: bits[2:0].
  - addr 1, mask, R/W: bits[2:0]. Writing mask=0 deasserts irq next cycle; pending bits are kept.
  - addr 2, event counts, R, write clears: {cnt2, cnt1, cnt0} packed from bit 0, CNT_W bits each.
  - addr 3, status, R, writes ignored: {irq at bit 31, irq_cause at bits[1:0], synchronised cnt_out levels at bits[6:4]}.
- Concurrent events on all three channels in the same cycle all set pending and all increment their counters.

Optional Feature:
Macro: COUNTER_IRQ_BOTHEDGE_EN.
- Defined: event_i = sync_i ^ hist_i, so both rising and falling edges set pending and count. This serves square-wave mode, where each half-period is an event.
- Undefined: rising edges only, as specified above.
- Register map and latency are identical in both builds.

Test Plan:
1. Reset, then mask=3'b111. Raise cnt_out[1] and hold 10 clk → pending=3'b010 after 3rd clk edge; irq=1 and irq_cause=1 after 4th edge; addr 2 reads cnt1=1.
2. Raise cnt_out[2] then cnt_out[0] with mask=3'b111 → irq_cause=0. Pulse irq_ack → pending=3'b100 and irq_cause=2 one clk later. Second irq_ack → irq=0, irq_cause=3.
3. mask=0, generate 300 rising edges on channel 0 → irq stays 0; pending[0]=1; cnt0 saturates at 255. Write addr 2 → cnt0=0.
4. Align an event_0 with a W1C write of 1 to addr 0 in the same cycle → pending[0] stays 1.
5. Assert rst while irq=1 and pending=3'b111 → irq=0, irq_cause=3, pending=0, mask=0 immediately. After rst release, cnt_out held high produces no event.
6. With COUNTER_IRQ_BOTHEDGE_EN: one full square period on channel 1 → cnt1=2. Without the macro → cnt1=1.
